gfmul_digit: RTL and testbench

GFMUL_DIGIT -- requirements
Module: gfmul_digit

---
 rtl/gfmul_digit_if.sv | 23 ++
 rtl/gfmul_digit.sv | 97 +++++++++
 tb/tb_gfmul_digit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/gfmul_digit_if.sv
// Request/key/result bundle for gfmul_digit. A request is taken at a rising edge
// where iCtext_valid and oReady are both high; oResult_valid is a one-cycle strobe.
interface gfmul_digit_if;
    logic [0:127] iHashkey;
    logic         iHashkey_valid;
    logic [127:0] iCtext;
    logic         iCtext_valid;
    logic         iAccum;
    logic         iClear;
    logic         oReady;
    logic [0:127] oResult;
    logic         oResult_valid;

    modport master (
        output iHashkey, iHashkey_valid, iCtext, iCtext_valid, iAccum, iClear,
        input  oReady, oResult, oResult_valid
    );

    modport slave (
        input  iHashkey, iHashkey_valid, iCtext, iCtext_valid, iAccum, iClear,
        output oReady, oResult, oResult_valid
    );
endinterface

// File: rtl/gfmul_digit.sv
// Digit-serial GF(2^128) multiplier in GCM bit order. It consumes DIGIT_W operand
// bits per cycle and keeps the last product as the GHASH accumulator.
module gfmul_digit #(
    parameter int DIGIT_W = 8
) (
    input  logic          iClk,
    input  logic          iRst_n,
    gfmul_digit_if.slave  bus,
    output logic          oState
);
    localparam int N  = 128 / DIGIT_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [0:127] R = {8'hE1, 120'h0};

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state;
    logic [0:127]  key;
    logic [0:127]  x;
    logic [0:127]  z;
    logic [0:127]  v;
    logic [CW-1:0] cnt;
    logic          ready;
    logic [0:127]  result;
    logic          result_valid;

    logic [0:127]  z_n;
    logic [0:127]  v_n;
    logic [0:127]  x_n;

    // Multiply by x: index 0 is the x^0 coefficient, so a right shift raises degree.
    function automatic logic [0:127] mulx(input logic [0:127] a);
        mulx = (a >> 1) ^ (a[127] ? R : 128'h0);
    endfunction

    always_comb begin
        z_n = z;
        v_n = v;
        for (int j = 0; j < DIGIT_W; j++) begin
            if (x[j]) z_n = z_n ^ v_n;
            v_n = mulx(v_n);
        end
        x_n = x << DIGIT_W;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state        <= IDLE;
            key          <= '0;
            x            <= '0;
            z            <= '0;
            v            <= '0;
            cnt          <= '0;
            ready        <= 1'b1;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iHashkey_valid) key <= bus.iHashkey;
                    if (bus.iClear) result <= '0;
                    if (bus.iCtext_valid) begin
                        // A coincident clear makes the accumulator contribute zero.
                        if (bus.iAccum)
                            x <= (bus.iClear ? 128'h0 : result) ^ bus.iCtext;
                        else
                            x <= bus.iCtext;
                        z     <= '0;
                        v     <= bus.iHashkey_valid ? bus.iHashkey : key;
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    z   <= z_n;
                    v   <= v_n;
                    x   <= x_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        result       <= z_n;
                        result_valid <= 1'b1;
                        ready        <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oReady        = ready;
    assign bus.oResult       = result;
    assign bus.oResult_valid = result_valid;
    assign oState            = (state == BUSY);
endmodule

// File: tb/tb_gfmul_digit.sv
// Directed bench for gfmul_digit: main instance at DIGIT_W=8, with DIGIT_W=1 and
// DIGIT_W=128 instances that share the data inputs and see requests only when enabled.
module tb_gfmul_digit;
    localparam logic [127:0] H1  = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
    localparam logic [127:0] C1  = 128'h0388DACE60B6A392F328C2B971B2FE78;
    localparam logic [127:0] Z1  = 128'h5E2EC746917062882C85B0685353DEB7;
    localparam logic [127:0] H2  = 128'h73A23D80121DE2D5A850253FCF43120E;
    localparam logic [127:0] D1  = 128'hD609B1F056637A0D46DF998D88E52E00;
    localparam logic [127:0] D2  = 128'hB2C2846512153524C0895E8100000000;
    localparam logic [127:0] D3  = 128'h701AFA1CC039C0D765128A665DAB6924;
    localparam logic [127:0] A1  = 128'h9CABBD91899C1413AA7AD629C1DF12CD;
    localparam logic [127:0] A2  = 128'hB99ABF6BDBD18B8E148F8030F0686F28;
    localparam logic [127:0] A3  = 128'h8B5BD74B9A65A459150392C3872BCE7F;
    localparam logic [127:0] HON = 128'h80000000000000000000000000000000;
    localparam logic [127:0] CID = 128'hA56E0F6B50DEAA57C94FF5D812CAC706;

    logic clk;
    logic rst_n;
    logic side_en;
    logic st8, st1, st128;
    int   checks;
    int   failures;
    int   l8, l1, l128, p8, p1, p128;
    logic rv8;

    gfmul_digit_if ifm ();
    gfmul_digit_if if1 ();
    gfmul_digit_if if128 ();

    assign if1.iHashkey         = ifm.iHashkey;
    assign if1.iCtext           = ifm.iCtext;
    assign if1.iAccum           = ifm.iAccum;
    assign if1.iHashkey_valid   = ifm.iHashkey_valid & side_en;
    assign if1.iCtext_valid     = ifm.iCtext_valid & side_en;
    assign if1.iClear           = ifm.iClear & side_en;
    assign if128.iHashkey       = ifm.iHashkey;
    assign if128.iCtext         = ifm.iCtext;
    assign if128.iAccum         = ifm.iAccum;
    assign if128.iHashkey_valid = ifm.iHashkey_valid & side_en;
    assign if128.iCtext_valid   = ifm.iCtext_valid & side_en;
    assign if128.iClear         = ifm.iClear & side_en;

    gfmul_digit #(.DIGIT_W(8))   u8   (.iClk(clk), .iRst_n(rst_n), .bus(ifm.slave),   .oState(st8));
    gfmul_digit #(.DIGIT_W(1))   u1   (.iClk(clk), .iRst_n(rst_n), .bus(if1.slave),   .oState(st1));
    gfmul_digit #(.DIGIT_W(128)) u128 (.iClk(clk), .iRst_n(rst_n), .bus(if128.slave), .oState(st128));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [127:0] c, input logic acc, input logic clr,
                         input logic [127:0] h, input logic hv);
        @(negedge clk);
        ifm.iCtext         = c;
        ifm.iAccum         = acc;
        ifm.iClear         = clr;
        ifm.iHashkey       = h;
        ifm.iHashkey_valid = hv;
        ifm.iCtext_valid   = 1'b1;
        @(posedge clk);
        #1;
        ifm.iCtext_valid   = 1'b0;
        ifm.iClear         = 1'b0;
        ifm.iHashkey_valid = 1'b0;
    endtask

    // Latency is counted in edges after the accepting edge.
    task automatic observe(input int cycles);
        l8 = 0; l1 = 0; l128 = 0; p8 = 0; p1 = 0; p128 = 0; rv8 = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (ifm.oResult_valid) begin
                p8++;
                if (l8 == 0) begin l8 = i + 1; rv8 = ifm.oReady; end
            end
            if (if1.oResult_valid) begin p1++; if (l1 == 0) l1 = i + 1; end
            if (if128.oResult_valid) begin p128++; if (l128 == 0) l128 = i + 1; end
        end
    endtask

    task automatic wait_valid(input string tag, input int limit);
        logic got;
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (ifm.oResult_valid) begin got = 1'b1; break; end
        end
        chk(tag, 128'(got), 128'd1);
    endtask

    initial begin
        checks = 0; failures = 0; side_en = 1'b1;
        ifm.iHashkey = '0; ifm.iHashkey_valid = 1'b0; ifm.iCtext = '0;
        ifm.iCtext_valid = 1'b0; ifm.iAccum = 1'b0; ifm.iClear = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 128'(ifm.oReady), 128'd1);
        chk("rst_result", ifm.oResult, 128'd0);
        chk("rst_valid", 128'(ifm.oResult_valid), 128'd0);
        chk("rst_state", 128'(st8), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // No key loaded yet: product must be zero.
        issue(CID, 1'b0, 1'b0, HON, 1'b0);
        chk("busy_ready", 128'(ifm.oReady), 128'd0);
        observe(140);
        chk("nokey_w8", ifm.oResult, 128'd0);
        chk("nokey_w1", if1.oResult, 128'd0);
        chk("nokey_w128", if128.oResult, 128'd0);
        chk("nokey_pulses", 128'(p8), 128'd1);

        // Identity key, loaded together with the request.
        issue(CID, 1'b0, 1'b0, HON, 1'b1);
        observe(140);
        chk("ident_w8", ifm.oResult, CID);
        chk("ident_w1", if1.oResult, CID);
        chk("ident_w128", if128.oResult, CID);
        issue(128'd0, 1'b0, 1'b0, HON, 1'b0);
        observe(140);
        chk("zero_w8", ifm.oResult, 128'd0);

        // Reference product and latency at all three digit widths.
        issue(C1, 1'b0, 1'b0, H1, 1'b1);
        observe(140);
        chk("mul_w8", ifm.oResult, Z1);
        chk("mul_w1", if1.oResult, Z1);
        chk("mul_w128", if128.oResult, Z1);
        chk("lat_w8", 128'(l8), 128'd16);
        chk("lat_w1", 128'(l1), 128'd128);
        chk("lat_w128", 128'(l128), 128'd1);
        chk("pulse_w8", 128'(p8), 128'd1);
        chk("pulse_w1", 128'(p1), 128'd1);
        chk("pulse_w128", 128'(p128), 128'd1);
        chk("ready_at_valid", 128'(rv8), 128'd1);

        // GHASH chain; the first step clears a nonzero accumulator in the same cycle.
        side_en = 1'b0;
        issue(D1, 1'b1, 1'b1, H2, 1'b1);
        wait_valid("acc1_to", 40);
        chk("acc1", ifm.oResult, A1);
        issue(D2, 1'b1, 1'b0, H2, 1'b0);
        wait_valid("acc2_to", 40);
        chk("acc2", ifm.oResult, A2);
        issue(D3, 1'b1, 1'b0, H2, 1'b0);
        wait_valid("acc3_to", 40);
        chk("acc3", ifm.oResult, A3);

        // Standalone clear: zero the accumulator without a strobe.
        @(negedge clk);
        ifm.iClear = 1'b1;
        @(posedge clk);
        #1;
        ifm.iClear = 1'b0;
        chk("clear_result", ifm.oResult, 128'd0);
        observe(5);
        chk("clear_no_pulse", 128'(p8), 128'd0);

        // Key load, clear and new request while busy must all be ignored.
        issue(C1, 1'b0, 1'b0, H1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        ifm.iHashkey = H2; ifm.iHashkey_valid = 1'b1; ifm.iClear = 1'b1;
        ifm.iCtext = D1; ifm.iAccum = 1'b1; ifm.iCtext_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("dist_busy", 128'(ifm.oReady), 128'd0);
        ifm.iHashkey_valid = 1'b0; ifm.iClear = 1'b0; ifm.iCtext_valid = 1'b0;
        observe(30);
        chk("dist_result", ifm.oResult, Z1);
        chk("dist_pulses", 128'(p8), 128'd1);
        chk("dist_lat", 128'(l8), 128'd12);

        // Reset in the middle of an operation.
        issue(C1, 1'b0, 1'b0, H1, 1'b1);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 128'(ifm.oReady), 128'd1);
        chk("midrst_result", ifm.oResult, 128'd0);
        chk("midrst_valid", 128'(ifm.oResult_valid), 128'd0);
        chk("midrst_state", 128'(st8), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        observe(30);
        chk("midrst_no_pulse", 128'(p8), 128'd0);
        issue(C1, 1'b0, 1'b0, H1, 1'b1);
        observe(30);
        chk("after_rst_result", ifm.oResult, Z1);
        chk("after_rst_lat", 128'(l8), 128'd16);
        chk("after_rst_pulses", 128'(p8), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
